// File: rtl/microwave_power_controller.sv
// rtl/microwave_power_controller.sv - microwave keypad entry, BCD countdown, interlock and power duty cycling
//
// Purpose: one sequential block that takes keypad time/power entry, counts a
// BCD mm:ss value down once per CLK_DIV cycles while cooking, and duty-cycles
// the magnetron over a POWER_LEVELS-second period.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   keypad[9:0]          one-hot digit keys (bit n = digit n)
//   pwr_sel              while high in IDLE/DONE, a key sets the power level
//   startn/stopn         active-low start and stop, acting on falling edges
//   clearn               active-low level clear
//   door_closed          1 = door shut
//   mag_on               magnetron enable
//   sec_ones/sec_tens    BCD seconds digits
//   mins                 BCD minute digits, least significant in [3:0]
//   power_level          current power, 1..POWER_LEVELS
//   state                0=IDLE 1=COOK 2=PAUSED 3=DONE
//   done                 one-cycle pulse on entry to DONE
module microwave_power_controller #(
    parameter int CLK_DIV      = 1000,
    parameter int MIN_DIGITS   = 1,
    parameter int POWER_LEVELS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [9:0]              keypad,
    input  logic                    pwr_sel,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    output logic                    mag_on,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic [3:0]              power_level,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int         PW = $clog2(CLK_DIV);
    localparam int         MW = 4 * MIN_DIGITS;
    localparam logic [3:0] PL = 4'(POWER_LEVELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COOK   = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [MW-1:0]   mins_q, mins_d;
    logic [3:0]      power_q, power_d;
    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [3:0]      duty_q, duty_d;
    logic            done_q, done_d;
    logic            startn_prev_q, startn_prev_d;
    logic            stopn_prev_q, stopn_prev_d;
    logic [9:0]      keypad_prev_q, keypad_prev_d;

    logic            start_ev, stop_ev, key_ev, key_onehot;
    logic [3:0]      key_val, key_power;
    logic            tick, time_zero, last_second;
    logic [MW-1:0]   mins_dec, mins_shift;
    logic            borrow;

    assign start_ev   = startn_prev_q & ~startn;
    assign stop_ev    = stopn_prev_q & ~stopn;
    assign key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_ev     = key_onehot && (keypad_prev_q == 10'd0);
    assign key_power  = ((key_val == 4'd0) || (key_val > PL)) ? PL : key_val;
    assign tick       = (prescaler_q == PW'(CLK_DIV - 1));
    assign time_zero  = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == '0);
    // The only pre-tick value whose decrement lands on zero is 00:01.
    assign last_second = (sec_ones_q == 4'd1) && (sec_tens_q == 4'd0) && (mins_q == '0);

    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_val = 4'(i);
        end
    end

    // Multi-digit BCD minute decrement with ripple borrow, plus the left shift
    // used on digit entry (sec_tens moves into the lowest minute digit).
    always_comb begin
        mins_dec   = mins_q;
        mins_shift = mins_q;
        borrow     = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (mins_q[4*i +: 4] == 4'd0) begin
                    mins_dec[4*i +: 4] = 4'd9;
                end else begin
                    mins_dec[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
        mins_shift[3:0] = sec_tens_q;
        for (int i = 1; i < MIN_DIGITS; i++) begin
            mins_shift[4*i +: 4] = mins_q[4*(i-1) +: 4];
        end
    end

    always_comb begin
        state_d       = state_q;
        sec_ones_d    = sec_ones_q;
        sec_tens_d    = sec_tens_q;
        mins_d        = mins_q;
        power_d       = power_q;
        prescaler_d   = prescaler_q;
        duty_d        = duty_q;
        done_d        = 1'b0;
        startn_prev_d = startn;
        stopn_prev_d  = stopn;
        keypad_prev_d = keypad;

        if (!clearn) begin
            state_d     = S_IDLE;
            sec_ones_d  = 4'd0;
            sec_tens_d  = 4'd0;
            mins_d      = '0;
            power_d     = PL;
            prescaler_d = '0;
            duty_d      = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Stop and start both consume the cycle, so a key arriving
                    // alongside either is dropped.
                    if (!stop_ev) begin
                        if (start_ev) begin
                            if (door_closed && !time_zero) begin
                                state_d     = S_COOK;
                                prescaler_d = '0;
                                duty_d      = 4'd0;
                            end
                        end else if (key_ev) begin
                            if (pwr_sel) begin
                                power_d = key_power;
                            end else begin
                                sec_ones_d = key_val;
                                sec_tens_d = sec_ones_q;
                                mins_d     = mins_shift;
                            end
                        end
                    end
                end
                S_COOK: begin
                    if (stop_ev || !door_closed) begin
                        state_d     = S_PAUSED;
                        prescaler_d = '0;
                    end else if (tick) begin
                        prescaler_d = '0;
                        duty_d      = (duty_q == PL - 4'd1) ? 4'd0 : duty_q + 4'd1;
                        if (sec_ones_q != 4'd0) begin
                            sec_ones_d = sec_ones_q - 4'd1;
                        end else if (sec_tens_q != 4'd0) begin
                            sec_ones_d = 4'd9;
                            sec_tens_d = sec_tens_q - 4'd1;
                        end else begin
                            sec_ones_d = 4'd9;
                            sec_tens_d = 4'd5;
                            mins_d     = mins_dec;
                        end
                        if (last_second) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        prescaler_d = prescaler_q + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (stop_ev) begin
                        state_d     = S_IDLE;
                        sec_ones_d  = 4'd0;
                        sec_tens_d  = 4'd0;
                        mins_d      = '0;
                        prescaler_d = '0;
                        duty_d      = 4'd0;
                    end else if (start_ev && door_closed) begin
                        state_d     = S_COOK;
                        prescaler_d = '0;
                    end
                end
                S_DONE: begin
                    if (stop_ev) begin
                        state_d = S_IDLE;
                    end else if (!start_ev && key_ev) begin
                        state_d    = S_IDLE;
                        sec_ones_d = pwr_sel ? 4'd0 : key_val;
                        sec_tens_d = 4'd0;
                        mins_d     = '0;
                        if (pwr_sel) power_d = key_power;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sec_ones_q    <= 4'd0;
            sec_tens_q    <= 4'd0;
            mins_q        <= '0;
            power_q       <= PL;
            prescaler_q   <= '0;
            duty_q        <= 4'd0;
            done_q        <= 1'b0;
            startn_prev_q <= 1'b1;
            stopn_prev_q  <= 1'b1;
            keypad_prev_q <= 10'd0;
        end else begin
            state_q       <= state_d;
            sec_ones_q    <= sec_ones_d;
            sec_tens_q    <= sec_tens_d;
            mins_q        <= mins_d;
            power_q       <= power_d;
            prescaler_q   <= prescaler_d;
            duty_q        <= duty_d;
            done_q        <= done_d;
            startn_prev_q <= startn_prev_d;
            stopn_prev_q  <= stopn_prev_d;
            keypad_prev_q <= keypad_prev_d;
        end
    end

    // Door state is used directly so an opening door cuts power immediately.
    assign mag_on      = (state_q == S_COOK) && door_closed && (duty_q < power_q);
    assign sec_ones    = sec_ones_q;
    assign sec_tens    = sec_tens_q;
    assign mins        = mins_q;
    assign power_level = power_q;
    assign state       = state_q;
    assign done        = done_q;

endmodule

// File: tb/tb_microwave_power_controller.sv
// tb/tb_microwave_power_controller.sv - self-checking bench for microwave_power_controller
module tb_microwave_power_controller;

    localparam int CLK_DIV    = 4;
    localparam int MIN_DIGITS = 2;
    localparam int PL         = 10;
    localparam int TMOD       = 10000;

    logic       clock;
    logic       reset;
    logic [9:0] keypad;
    logic       pwr_sel, startn, stopn, clearn, door_closed;
    logic       mag_on;
    logic [3:0] sec_ones, sec_tens;
    logic [7:0] mins;
    logic [3:0] power_level;
    logic [1:0] state;
    logic       done;

    microwave_power_controller #(
        .CLK_DIV(CLK_DIV), .MIN_DIGITS(MIN_DIGITS), .POWER_LEVELS(PL)
    ) dut (
        .clock(clock), .reset(reset), .keypad(keypad), .pwr_sel(pwr_sel),
        .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .mag_on(mag_on), .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
        .power_level(power_level), .state(state), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: time is held as a plain decimal number (mmss).
    int       m_state, m_t, m_pwr, m_presc, m_duty;
    bit       m_done, m_ps, m_pst;
    bit [9:0] m_pk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic key_action(input int kv);
        if (pwr_sel) m_pwr = (kv == 0 || kv > PL) ? PL : kv;
        else         m_t   = (m_t * 10 + kv) % TMOD;
    endtask

    task automatic model_step();
        bit sev, pev, kev;
        int kv;
        sev = m_ps && !startn;
        pev = m_pst && !stopn;
        kev = ($countones(keypad) == 1) && (m_pk == 10'd0);
        kv  = $clog2(keypad);
        m_done = 1'b0;
        if (reset) begin
            m_state = 0; m_t = 0; m_pwr = PL; m_presc = 0; m_duty = 0;
        end else if (!clearn) begin
            m_state = 0; m_t = 0; m_pwr = PL; m_presc = 0; m_duty = 0;
        end else begin
            case (m_state)
                0: if (!pev) begin
                       if (sev) begin
                           if (door_closed && m_t != 0) begin
                               m_state = 1; m_presc = 0; m_duty = 0;
                           end
                       end else if (kev) key_action(kv);
                   end
                1: if (pev || !door_closed) begin
                       m_state = 2; m_presc = 0;
                   end else if (m_presc == CLK_DIV - 1) begin
                       m_presc = 0;
                       m_duty  = (m_duty + 1) % PL;
                       m_t     = (m_t % 100 != 0) ? m_t - 1 : m_t - 41;
                       if (m_t == 0) begin m_state = 3; m_done = 1'b1; end
                   end else m_presc++;
                2: if (pev) begin
                       m_state = 0; m_t = 0; m_presc = 0; m_duty = 0;
                   end else if (sev && door_closed) begin
                       m_state = 1; m_presc = 0;
                   end
                default: if (pev) m_state = 0;
                   else if (!sev && kev) begin
                       m_state = 0; m_t = 0; key_action(kv);
                   end
            endcase
        end
        if (reset) begin m_ps = 1; m_pst = 1; m_pk = '0; end
        else begin m_ps = startn; m_pst = stopn; m_pk = keypad; end
    endtask

    task automatic check_model();
        int em;
        em = (((m_t / 1000) % 10) << 4) | ((m_t / 100) % 10);
        chk("m_state", state, m_state);
        chk("m_sec_ones", sec_ones, m_t % 10);
        chk("m_sec_tens", sec_tens, (m_t / 10) % 10);
        chk("m_mins", mins, em);
        chk("m_power", power_level, m_pwr);
        chk("m_done", done, m_done);
        chk("m_mag_on", mag_on, (m_state == 1 && door_closed && m_duty < m_pwr) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input int d, input bit p);
        keypad = 10'd1 << d; pwr_sel = p; cycle();
        keypad = '0; pwr_sel = 1'b0; cycle();
    endtask

    task automatic start_pulse();
        startn = 1'b0; cycle(); startn = 1'b1; cycle();
    endtask

    task automatic stop_pulse();
        stopn = 1'b0; cycle(); stopn = 1'b1; cycle();
    endtask

    task automatic clear_pulse();
        clearn = 1'b0; cycle(); clearn = 1'b1; cycle();
    endtask

    task automatic chk_time(input string name, input int so, input int st, input int mn);
        chk({name, "_so"}, sec_ones, so);
        chk({name, "_st"}, sec_tens, st);
        chk({name, "_mins"}, mins, mn);
    endtask

    typedef struct {
        logic [9:0] kp;
        logic       ps, stn, spn, cln, dc;
        logic [1:0] st;
        logic [3:0] so, tn;
        logic [7:0] mn;
        logic [3:0] pw;
        logic       mg, dn;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic [9:0] kp, input logic stn, input logic cln,
                        input logic [1:0] st, input logic [3:0] so, input logic [3:0] tn,
                        input logic [7:0] mn, input logic mg);
        vec_t v;
        v.kp = kp; v.ps = 1'b0; v.stn = stn; v.spn = 1'b1; v.cln = cln; v.dc = 1'b1;
        v.st = st; v.so = so; v.tn = tn; v.mn = mn; v.pw = 4'd10; v.mg = mg; v.dn = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; keypad = '0; pwr_sel = 1'b0; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1;
        cycles(2);
        reset = 1'b0;
        chk("reset_state", state, 0);
        chk_time("reset", 0, 0, 0);
        chk("reset_power", power_level, 10);
        chk("reset_mag", mag_on, 0);
        chk("reset_done", done, 0);

        // Digit entry with MIN_DIGITS=2, rejection of multi-hot and held keys,
        // clear, then the 0:10 countdown start.
        addv(10'h002, 1, 1, 0, 1, 0, 8'h00, 0);
        addv(10'h000, 1, 1, 0, 1, 0, 8'h00, 0);
        addv(10'h004, 1, 1, 0, 2, 1, 8'h00, 0);
        addv(10'h000, 1, 1, 0, 2, 1, 8'h00, 0);
        addv(10'h008, 1, 1, 0, 3, 2, 8'h01, 0);
        addv(10'h000, 1, 1, 0, 3, 2, 8'h01, 0);
        addv(10'h010, 1, 1, 0, 4, 3, 8'h12, 0);
        addv(10'h000, 1, 1, 0, 4, 3, 8'h12, 0);
        addv(10'h020, 1, 1, 0, 5, 4, 8'h23, 0);
        addv(10'h000, 1, 1, 0, 5, 4, 8'h23, 0);
        addv(10'h003, 1, 1, 0, 5, 4, 8'h23, 0);
        addv(10'h000, 1, 1, 0, 5, 4, 8'h23, 0);
        addv(10'h008, 1, 1, 0, 3, 5, 8'h34, 0);
        addv(10'h008, 1, 1, 0, 3, 5, 8'h34, 0);
        addv(10'h000, 1, 0, 0, 0, 0, 8'h00, 0);
        addv(10'h002, 1, 1, 0, 1, 0, 8'h00, 0);
        addv(10'h002, 1, 1, 0, 1, 0, 8'h00, 0);
        addv(10'h000, 1, 1, 0, 1, 0, 8'h00, 0);
        addv(10'h001, 1, 1, 0, 0, 1, 8'h00, 0);
        addv(10'h000, 1, 1, 0, 0, 1, 8'h00, 0);
        addv(10'h000, 0, 1, 1, 0, 1, 8'h00, 1);
        addv(10'h000, 0, 1, 1, 0, 1, 8'h00, 1);
        addv(10'h000, 1, 1, 1, 0, 1, 8'h00, 1);
        addv(10'h000, 1, 1, 1, 0, 1, 8'h00, 1);
        addv(10'h000, 1, 1, 1, 9, 0, 8'h00, 1);
        foreach (tbl[i]) begin
            keypad = tbl[i].kp; pwr_sel = tbl[i].ps; startn = tbl[i].stn;
            stopn = tbl[i].spn; clearn = tbl[i].cln; door_closed = tbl[i].dc;
            cycle();
            chk($sformatf("vec%0d_state", i), state, tbl[i].st);
            chk($sformatf("vec%0d_so", i), sec_ones, tbl[i].so);
            chk($sformatf("vec%0d_st", i), sec_tens, tbl[i].tn);
            chk($sformatf("vec%0d_mins", i), mins, tbl[i].mn);
            chk($sformatf("vec%0d_pwr", i), power_level, tbl[i].pw);
            chk($sformatf("vec%0d_mag", i), mag_on, tbl[i].mg);
            chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
        end
        keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;

        // Remaining nine seconds, then the DONE pulse.
        cycles(35);
        chk("t1_pre_state", state, 1);
        chk_time("t1_pre", 1, 0, 0);
        cycle();
        chk("t1_done_state", state, 3);
        chk("t1_done_pulse", done, 1);
        chk("t1_done_mag", mag_on, 0);
        chk_time("t1_done", 0, 0, 0);
        cycle();
        chk("t1_done_drop", done, 0);
        chk("t1_done_hold", state, 3);

        // Minute borrow: 1:00 -> 0:59 -> 0:58.
        press(1, 0);
        chk("t2_key_idle", state, 0);
        press(0, 0);
        press(0, 0);
        chk_time("t2_entry", 0, 0, 8'h01);
        start_pulse();
        cycles(3);
        chk_time("t2_059", 9, 5, 0);
        cycles(4);
        chk_time("t2_058", 8, 5, 0);
        clear_pulse();

        // Power 3: three seconds on, seven off over a 20 s cook.
        press(3, 1);
        chk("t3_power", power_level, 3);
        press(2, 0);
        press(0, 0);
        chk_time("t3_entry", 0, 2, 0);
        start_pulse();
        for (int s = 0; s < 20; s++) begin
            chk($sformatf("t3_mag_s%0d", s), mag_on, (s % 10) < 3 ? 1 : 0);
            cycles(s == 0 ? 3 : 4);
        end
        chk("t3_end_state", state, 3);
        press(5, 1);
        chk("t3_power5", power_level, 5);
        press(0, 1);
        chk("t3_power0", power_level, 10);

        // Door opening mid-cook, then resume.
        press(1, 0);
        press(6, 0);
        start_pulse();
        cycles(3);
        chk_time("t4_015", 5, 1, 0);
        cycles(2);
        door_closed = 1'b0;
        #1;
        chk("t4_mag_comb", mag_on, 0);
        cycle();
        chk("t4_paused", state, 2);
        cycles(3);
        chk_time("t4_held", 5, 1, 0);
        door_closed = 1'b1;
        start_pulse();
        chk("t4_resumed", state, 1);
        cycles(2);
        chk_time("t4_not_yet", 5, 1, 0);
        cycle();
        chk_time("t4_014", 4, 1, 0);

        // Interlock, double stop, clear mid-cook.
        clear_pulse();
        press(5, 0);
        door_closed = 1'b0; startn = 1'b0;
        cycle();
        chk("t5_door_start", state, 0);
        startn = 1'b1; door_closed = 1'b1;
        cycle();
        press(4, 1);
        start_pulse();
        chk("t5_cook", state, 1);
        stop_pulse();
        chk("t5_pause", state, 2);
        stop_pulse();
        chk("t5_idle", state, 0);
        chk_time("t5_zero", 0, 0, 0);
        chk("t5_power_kept", power_level, 4);
        press(9, 0);
        start_pulse();
        cycles(2);
        clearn = 1'b0;
        cycle();
        chk("t5_clr_state", state, 0);
        chk_time("t5_clr", 0, 0, 0);
        chk("t5_clr_power", power_level, 10);
        clearn = 1'b1;
        cycle();

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(99);
            if (r < 70)      keypad = '0;
            else if (r < 92) keypad = 10'd1 << $urandom_range(9);
            else             keypad = 10'($urandom);
            pwr_sel     = ($urandom_range(3) == 0);
            startn      = ($urandom_range(9) != 0);
            stopn       = ($urandom_range(29) != 0);
            clearn      = ($urandom_range(99) != 0);
            door_closed = ($urandom_range(9) != 0);
            reset       = ($urandom_range(499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/microwave_power_controller.md
Name: microwave_power_controller

Overview:
Parametrised successor to the single-mode microwave top level. Integrates keypad time entry, a configurable-width BCD mm:ss countdown, start/stop/clear/door interlock and magnetron power-level duty cycling in one sequential block. It drives the magnetron enable and raw BCD digits; the existing segment7_decoder, or a future wider variant, sits downstream.

Parameters:
CLK_DIV, 1000, clock cycles per 1 s tick; legal range >=2.
MIN_DIGITS, 1, number of BCD minute digits; legal range 1..3.
POWER_LEVELS, 10, maximum power level; also the duty period in seconds; legal range 2..10.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; overrides all other inputs
keypad  input  10  one-hot digit keys; bit n = digit n
pwr_sel  input  1  active-high level; while high in IDLE, the next digit sets the power level
startn  input  1  active-low start
stopn  input  1  active-low stop/pause
clearn  input  1  active-low clear
door_closed  input  1  1 = door shut
mag_on  output  1  magnetron enable; combinational from registered state
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
mins  output  4*MIN_DIGITS  BCD minutes, least significant digit in [3:0]
power_level  output  4  current power, 1..POWER_LEVELS
state  output  2  0=IDLE 1=COOK 2=PAUSED 3=DONE
done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values: state=IDLE, all digits 0, power_level=POWER_LEVELS, done=0, mag_on=0, prescaler=0, duty_cnt=0. Edge-detect history registers reset to 1 (startn/stopn) and 0 (keypad).
- Edge detection:
  - startn/stopn act only on a 1→0 transition.
  - clearn is level-sensitive: while low, the block is held in the cleared condition.
  - A key acts only when keypad is exactly one-hot and the previous cycle's keypad was all-zero. Multi-hot or held keys are ignored.
- Event priority within one cycle: reset > clear > stop > door open > start > key.
- Clear: state=IDLE, all digits 0, power_level=POWER_LEVELS, prescaler=0, duty_cnt=0.
- IDLE:
  - Key with pwr_sel=0: digits shift left. sec_ones←key, sec_tens←old sec_ones, mins[3:0]←old sec_tens, each higher minute digit←the next lower one. The top digit is discarded.
  - Key with pwr_sel=1: power_level←key. A key of 0 or any value >POWER_LEVELS loads POWER_LEVELS. Digits are unchanged.
  - Start with door_closed=1 and nonzero time: →COOK, prescaler=0, duty_cnt=0.
  - Start with zero time or door open: ignored.
- COOK:
  - Prescaler counts 0..CLK_DIV-1. tick = (prescaler==CLK_DIV-1).
  - On tick, decrement the time:
    - If sec_ones>0: sec_ones-1.
    - Else if sec_tens>0: sec_ones=9, sec_tens-1.
    - Else: sec_tens=5, sec_ones=9, and mins decrements as a BCD multi-digit value.
    - Entered tens of 6-9 are legal and count down as is; e.g. 90 takes 90 ticks.
  - duty_cnt increments on each tick and wraps at POWER_LEVELS-1→0.
  - When a tick makes the time reach 0: next cycle state=DONE, and done=1 for exactly that one cycle.
  - Stop or door_closed=0: →PAUSED. Time, power_level and duty_cnt are held; prescaler is reset to 0.
  - Keys are ignored.
- PAUSED:
  - Start with door closed: →COOK; prescaler starts from 0.
  - Stop: →IDLE with digits cleared; power_level is kept.
  - Keys are ignored.
- DONE:
  - A key behaves as in IDLE starting from zeroed digits, and state→IDLE.
  - Start is ignored.
  - Stop: →IDLE.
- mag_on = (state==COOK) & door_closed & (duty_cnt < power_level).
  - Door opening drops mag_on in the same cycle, before the state register updates.
  - power_level=POWER_LEVELS gives continuous operation.
- Maximum time: all digits 9 (e.g. 9:99 for MIN_DIGITS=1). No saturation is applied to shifted-in digits.

Test Plan:
1. CLK_DIV=4. Reset, press keys 1,0 (shifts to 0:10), then start with door closed → state=COOK, mag_on=1, 0:09 after 4 cycles, DONE after 40 cycles with done high for exactly 1 cycle, then mag_on=0.
2. Enter 1:00, start; count through 1:00→0:59→0:58 → borrow across minutes is correct.
3. pwr_sel=1 plus key 3, then enter 0:20 and start → mag_on high 3 ticks, low 7 ticks, repeating; power key 0 → power_level=10.
4. During COOK at 0:15, drop door_closed → mag_on=0 in the same cycle and state=PAUSED, 0:15 held. Close the door and start → resumes, next decrement after 4 cycles.
5. Same cycle startn falling and door_closed=0 in IDLE → remains IDLE. Stop pressed twice (COOK→PAUSED→IDLE) → digits 0 and power retained. clearn low mid-COOK → IDLE, zeros, power=10.
6. MIN_DIGITS=2. Enter keys 1,2,3,4,5 → mins=23 (top digit discarded), sec=45. Keypad 0x003 and a held key → no shift.
